// File: rtl/picosoc_mem_arbiter.sv
// Two-master round-robin arbiter for a PicoRV32-native memory port, with whole-transaction
// grant locking and a watchdog that completes a stalled transfer with a fixed read value.
module picosoc_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF,
    parameter bit          M0_FIRST       = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        timeout_pulse
);

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);
    localparam bit          WdogEn     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    state_e      r_state;
    logic        r_owner;
    logic        r_prio;
    logic [15:0] r_cnt;

    logic        w_own_valid;
    logic        w_grant;
    logic [15:0] w_cnt_inc;
    logic        w_done;
    logic [31:0] w_done_rdata;

    assign w_own_valid = r_owner ? m1_valid : m0_valid;
    assign w_cnt_inc   = r_cnt + 16'd1;
    // m1 wins when it is the only requester, or when both request and it holds priority
    assign w_grant     = m1_valid & (~m0_valid | r_prio);
    assign owner       = r_owner;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
            r_prio  <= !M0_FIRST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (m0_valid || m1_valid) begin
                        r_owner <= w_grant;
                        r_cnt   <= '0;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (s_ready) begin
                        r_prio  <= ~r_owner;
                        r_state <= StIdle;
                    end else if (!w_own_valid) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (WdogEn && (w_cnt_inc == TimeoutCnt)) begin
                            r_state <= StErr;
                        end
                    end
                end
                StErr: begin
                    r_prio  <= ~r_owner;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_valid       = 1'b0;
        s_instr       = 1'b0;
        s_addr        = '0;
        s_wdata       = '0;
        s_wstrb       = '0;
        timeout_pulse = 1'b0;
        w_done        = 1'b0;
        w_done_rdata  = '0;
        case (r_state)
            StBusy: begin
                s_valid      = w_own_valid;
                s_instr      = r_owner ? m1_instr : m0_instr;
                s_addr       = r_owner ? m1_addr  : m0_addr;
                s_wdata      = r_owner ? m1_wdata : m0_wdata;
                s_wstrb      = r_owner ? m1_wstrb : m0_wstrb;
                w_done       = s_ready;
                w_done_rdata = s_rdata;
            end
            StErr: begin
                w_done        = 1'b1;
                w_done_rdata  = TIMEOUT_RDATA;
                timeout_pulse = 1'b1;
            end
            default: ;
        endcase
        m0_ready = w_done & ~r_owner;
        m1_ready = w_done & r_owner;
        m0_rdata = m0_ready ? w_done_rdata : '0;
        m1_rdata = m1_ready ? w_done_rdata : '0;
    end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Scoreboard bench for picosoc_mem_arbiter: directed scenarios plus two randomized masters
// against an address-driven slave; a monitor checks grants, forwarding and responses.
module tb_picosoc_mem_arbiter;

    localparam int          TO       = 4;
    localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        owner, timeout_pulse;

    picosoc_mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (TO_RDATA),
        .M0_FIRST      (1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m0_valid     (m0_valid),
        .m0_instr     (m0_instr),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_wstrb     (m0_wstrb),
        .m0_ready     (m0_ready),
        .m0_rdata     (m0_rdata),
        .m1_valid     (m1_valid),
        .m1_instr     (m1_instr),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_wstrb     (m1_wstrb),
        .m1_ready     (m1_ready),
        .m1_rdata     (m1_rdata),
        .s_valid      (s_valid),
        .s_instr      (s_instr),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_ready      (s_ready),
        .s_rdata      (s_rdata),
        .owner        (owner),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        to;
        int          lat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          grant_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulse_cnt = 0;
    int          rc0 = 0;
    int          rc1 = 0;
    bit          slv_en = 1'b1;
    bit          dir_en = 1'b1;
    int          dir_delay = 0;
    logic [31:0] dir_data = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Slave behaviour: wait cycles and read data are a function of the address,
    // or fixed values while a directed scenario runs.
    function automatic int rsp_delay(input logic [31:0] a);
        return dir_en ? dir_delay : int'(a[4:2]);
    endfunction

    function automatic logic [31:0] rsp_data(input logic [31:0] a);
        return dir_en ? dir_data : ({a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F);
    endfunction

    initial begin
        int cnt;
        cnt = 0;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (slv_en) begin
                s_ready = 1'b0;
                s_rdata = '0;
                if (resetn && s_valid) begin
                    if (cnt == rsp_delay(s_addr)) begin
                        s_ready = 1'b1;
                        s_rdata = rsp_data(s_addr);
                        cnt     = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: arbitration model, forwarding check and response scoreboard.
    initial begin
        logic [1:0] prev_v;
        logic       prev_sv;
        int         prio_m, cur_own, busy_cyc, exp_own;
        exp_t       e;
        prev_v = '0; prev_sv = 1'b0; prio_m = 0; cur_own = 0; busy_cyc = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_v = '0; prev_sv = 1'b0; prio_m = 0; busy_cyc = 0;
            end else begin
                if (timeout_pulse) begin
                    pulse_cnt++;
                    check("s_valid during timeout", {31'b0, s_valid}, 32'd0);
                    check("timeout with ready", {31'b0, m0_ready | m1_ready}, 32'd1);
                end
                if (s_valid && !prev_sv) begin
                    check("grant had request", {31'b0, prev_v != 2'b00}, 32'd1);
                    exp_own = (prev_v == 2'b11) ? prio_m : (prev_v[1] ? 1 : 0);
                    check("grant owner", {31'b0, owner}, 32'(exp_own));
                    check("fwd addr", s_addr, exp_own == 1 ? m1_addr : m0_addr);
                    check("fwd wdata", s_wdata, exp_own == 1 ? m1_wdata : m0_wdata);
                    check("fwd wstrb", {28'b0, s_wstrb}, {28'b0, exp_own == 1 ? m1_wstrb : m0_wstrb});
                    check("fwd instr", {31'b0, s_instr}, {31'b0, exp_own == 1 ? m1_instr : m0_instr});
                    cur_own  = exp_own;
                    busy_cyc = 0;
                    grant_log.push_back(exp_own);
                end else begin
                    busy_cyc++;
                end
                if (m0_ready || m1_ready) begin
                    check("single ready", {31'b0, m0_ready & m1_ready}, 32'd0);
                    check("ready goes to owner", {31'b0, m1_ready}, 32'(cur_own));
                    if (m1_ready) rc1++; else rc0++;
                    if ((m1_ready ? q1.size() : q0.size()) == 0) begin
                        check("ready with no request outstanding", 32'd1, 32'd0);
                    end else begin
                        e = m1_ready ? q1.pop_front() : q0.pop_front();
                        check("rdata", m1_ready ? m1_rdata : m0_rdata, e.rd);
                        check("timeout flag", {31'b0, timeout_pulse}, {31'b0, e.to});
                        check("latency", 32'(busy_cyc), 32'(e.lat));
                    end
                    prio_m = m1_ready ? 0 : 1;
                end
                prev_sv = s_valid;
                prev_v  = {m1_valid, m0_valid};
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after dropping valid and the idle gap.
    task automatic master_txn(input int w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic ins, input int gap);
        exp_t e;
        int   d;
        bit   got;
        d     = rsp_delay(a);
        e.to  = (d >= TO);
        e.rd  = e.to ? TO_RDATA : rsp_data(a);
        e.lat = e.to ? TO : d;
        if (w == 0) begin
            q0.push_back(e);
            m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = ins;
        end else begin
            q1.push_back(e);
            m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = ins;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (w == 0) ? m0_ready : m1_ready;
        end
        check($sformatf("m%0d ready within bound", w), {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (w == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_master(input int w, input int n);
        logic [31:0] r, wd;
        logic [2:0]  d;
        logic [3:0]  ws;
        for (int i = 0; i < n; i++) begin
            r  = $urandom();
            wd = $urandom();
            d  = 3'($urandom_range(0, 5));
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
            master_txn(w, {r[31:5], d, 2'b00}, wd, ws, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global time limit: simulation still running, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        int p0, r0, r1;
        // Outputs stay at zero during reset even with active inputs.
        slv_en = 1'b0;
        s_ready = 1'b1;
        s_rdata = 32'hFFFF_FFFF;
        resetn = 1'b0;
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h1234; m0_wdata = 32'h55; m0_wstrb = 4'hF;
        m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h5678; m1_wdata = 32'h66; m1_wstrb = 4'h3;
        repeat (2) @(negedge clk);
        check("reset s_valid", {31'b0, s_valid}, 32'd0);
        check("reset s_addr", s_addr, 32'd0);
        check("reset m0_ready", {31'b0, m0_ready}, 32'd0);
        check("reset m1_rdata", m1_rdata, 32'd0);
        check("reset owner", {31'b0, owner}, 32'd0);
        check("reset timeout_pulse", {31'b0, timeout_pulse}, 32'd0);
        s_ready = 1'b0;
        s_rdata = '0;
        slv_en = 1'b1;

        // Single m0 read, slave ready two cycles after s_valid.
        do_reset();
        dir_en = 1'b1; dir_delay = 2; dir_data = 32'h1234_5678;
        q0.push_back('{rd: 32'h1234_5678, to: 1'b0, lat: 2});
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0; m0_wdata = '0;
        @(negedge clk);
        check("c0 s_valid", {31'b0, s_valid}, 32'd0);
        @(negedge clk);
        check("c1 s_valid", {31'b0, s_valid}, 32'd1);
        @(negedge clk);
        check("c2 m0_ready", {31'b0, m0_ready}, 32'd0);
        @(negedge clk);
        check("c3 m0_ready", {31'b0, m0_ready}, 32'd1);
        check("c3 m0_rdata", m0_rdata, 32'h1234_5678);
        check("c3 m1_ready", {31'b0, m1_ready}, 32'd0);
        @(posedge clk);
        #1;
        m0_valid = 1'b0;
        @(posedge clk);
        #1;

        // Both masters continuously valid, zero-wait slave: grants alternate from m0.
        do_reset();
        dir_delay = 0; dir_data = 32'h0F0F_1234;
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) master_txn(0, 32'h200 + 32'(i * 4), 32'h0, 4'h0, 1'b1, 0);
            for (int i = 0; i < 3; i++) master_txn(1, 32'h300 + 32'(i * 4), 32'h0, 4'h0, 1'b0, 0);
        join
        check("alt grant count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check($sformatf("alt grant %0d", i), 32'(grant_log[i]), 32'(i % 2));
        end

        // m1 write forwarded exactly; a late m0 request waits for the next arbitration.
        do_reset();
        dir_delay = 1; dir_data = 32'h7777_8888;
        r0 = rc0; r1 = rc1;
        grant_log.delete();
        fork
            master_txn(1, 32'h100, 32'hA5A5_A5A5, 4'b0011, 1'b0, 2);
            begin
                @(posedge clk);
                #1;
                master_txn(0, 32'h204, 32'h0, 4'h0, 1'b0, 0);
            end
        join
        check("m1 write ready pulses", 32'(rc1 - r1), 32'd1);
        check("late m0 ready pulses", 32'(rc0 - r0), 32'd1);
        check("late m0 granted second", 32'(grant_log.size() > 1 ? grant_log[1] : 9), 32'd0);

        // Watchdog expiry: four BUSY cycles, then one-cycle timeout completion.
        do_reset();
        dir_delay = 7; dir_data = 32'h1111_1111;
        p0 = pulse_cnt;
        master_txn(0, 32'h40, 32'hCAFE_0000, 4'hF, 1'b0, 0);
        check("one timeout pulse", 32'(pulse_cnt - p0), 32'd1);
        slv_en = 1'b0;
        s_ready = 1'b1;
        s_rdata = 32'h2222_3333;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("late s_ready m0_ready", {31'b0, m0_ready}, 32'd0);
            check("late s_ready m1_ready", {31'b0, m1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        s_ready = 1'b0;
        slv_en = 1'b1;

        // s_ready on the last BUSY cycle before expiry completes normally.
        do_reset();
        dir_delay = TO - 1; dir_data = 32'hCAFE_F00D;
        p0 = pulse_cnt;
        master_txn(0, 32'h44, 32'h0, 4'h0, 1'b0, 0);
        check("no pulse on boundary ready", 32'(pulse_cnt - p0), 32'd0);

        // Reset mid-transaction drops outputs and restores m0 priority.
        do_reset();
        dir_delay = 1; dir_data = 32'h0BAD_CAFE;
        master_txn(0, 32'h60, 32'h0, 4'h0, 1'b0, 0);
        dir_delay = 7;
        m1_valid = 1'b1; m1_addr = 32'h70; m1_wdata = 32'h99; m1_wstrb = 4'h1; m1_instr = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("busy before reset s_valid", {31'b0, s_valid}, 32'd1);
        check("busy before reset owner", {31'b0, owner}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset s_valid", {31'b0, s_valid}, 32'd0);
        check("async reset s_addr", s_addr, 32'd0);
        check("async reset m1_ready", {31'b0, m1_ready}, 32'd0);
        check("async reset owner", {31'b0, owner}, 32'd0);
        m1_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        q0.delete();
        q1.delete();
        dir_delay = 1;
        grant_log.delete();
        fork
            master_txn(0, 32'h64, 32'h0, 4'h0, 1'b0, 0);
            master_txn(1, 32'h74, 32'h0, 4'h0, 1'b0, 0);
        join
        check("post-reset first grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);

        // Randomized traffic from both masters against the address-driven slave.
        do_reset();
        dir_en = 1'b0;
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join
        repeat (3) @(posedge clk);
        check("m0 queue drained", 32'(q0.size()), 32'd0);
        check("m1 queue drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/picosoc_mem_arbiter.md
Name: picosoc_mem_arbiter

Overview:
- Two-master arbiter that shares one PicoRV32-native memory port (valid/ready, addr, wdata, wstrb, rdata) between the CPU (m0) and a second requester (m1, e.g. a DMA/debug engine).
- Sits between the requesters and the SoC address decoder, i.e. in front of the on-chip RAM, progmem, UART and iomem.
- Round-robin arbitration, whole-transaction grant locking, and a bus-timeout watchdog so a non-responding slave cannot hang either master.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without s_ready before forced completion; 0 disables the watchdog; max 65535 (16-bit counter).
- TIMEOUT_RDATA, 32'h DEAD_BEEF: read data returned to the owner on timeout.
- M0_FIRST, 1: initial round-robin priority after reset (1 = m0, 0 = m1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m0_valid / m1_valid  in  1  master request
- m0_instr / m1_instr  in  1  instruction fetch flag
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read
- m0_ready / m1_ready  out  1  transaction complete
- m0_rdata / m1_rdata  out  32  read data
- s_valid  out  1  request to slave side
- s_instr  out  1  forwarded instr flag
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_wstrb  out  4  forwarded strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- owner  out  1  current or last grant (0 = m0, 1 = m1)
- timeout_pulse  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- States: IDLE, BUSY, ERR. Registered: state, owner, prio, 16-bit cnt.
- Reset: state = IDLE, owner = 0, prio = M0_FIRST ? 0 : 1, cnt = 0. All outputs 0 while in reset: s_valid, m*_ready, timeout_pulse = 0; s_* buses and m*_rdata = 0.
- Master rule: valid, addr, wdata, wstrb and instr are held stable until ready. Ready is a single-cycle pulse. The master may present a new request in the cycle after ready.
- IDLE:
  - Only m0_valid: owner <= 0, go BUSY.
  - Only m1_valid: owner <= 1, go BUSY.
  - Both valid: owner <= prio, go BUSY.
  - Nothing is forwarded to the slave in IDLE; s_valid = 0. Arbitration therefore adds exactly 1 cycle of latency.
- BUSY:
  - s_valid = valid of owner. s_addr, s_wdata, s_wstrb, s_instr are muxed from owner.
  - Non-owner ready = 0, rdata = 0.
  - If s_ready: owner ready = 1 and owner rdata = s_rdata, same cycle (combinational); prio <= ~owner; go IDLE. s_valid is therefore low for at least one cycle between transactions.
  - Else, if owner valid has dropped (protocol violation): go IDLE with no ready and prio unchanged.
  - Else: cnt <= cnt + 1. If TIMEOUT_CYCLES != 0 and cnt + 1 == TIMEOUT_CYCLES, go ERR.
  - cnt clears to 0 on every entry into BUSY.
- Priority: s_ready in the same cycle the counter would expire completes normally; the watchdog never fires.
- ERR (one cycle):
  - s_valid = 0.
  - owner ready = 1, owner rdata = TIMEOUT_RDATA; write data is discarded.
  - timeout_pulse = 1; prio <= ~owner; go IDLE.
  - A late s_ready in ERR or IDLE is ignored.
- owner holds its value in IDLE (reflects the last grant).
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. A pending transaction is abandoned without ready.
- Timing: no combinational path from m*_valid to m*_ready. s_ready to m*_ready is combinational.

Test Plan:
- Single m0 read at addr 0x0000_0010: m0_valid at cycle 0, slave asserts s_ready 2 cycles after s_valid with s_rdata 0x1234_5678 -> s_valid rises at cycle 1; m0_ready = 1 with m0_rdata 0x1234_5678 at cycle 3; m1_ready stays 0.
- Both masters valid continuously, zero-wait slave, M0_FIRST = 1 -> grants alternate m0, m1, m0, m1 with owner toggling; each grant completes 1 cycle after it is taken; s_valid = 0 for one cycle between grants.
- m1 write: addr 0x0000_0100, wdata 0xA5A5_A5A5, wstrb 4'b0011 -> s_addr, s_wdata and s_wstrb match exactly while s_valid = 1; m1_ready pulses once; a late m0_valid waits in IDLE until the next arbitration.
- TIMEOUT_CYCLES = 4, slave never ready, m0 read -> 4 BUSY cycles, then ERR: m0_ready = 1, m0_rdata 0xDEAD_BEEF, timeout_pulse = 1 for exactly one cycle, s_valid = 0; a late s_ready afterwards causes no ready.
- TIMEOUT_CYCLES = 4, s_ready on the 4th BUSY cycle -> normal completion with s_rdata, timeout_pulse stays 0.
- resetn pulsed low during BUSY -> s_valid and all ready outputs drop asynchronously; after release, state = IDLE and prio = m0, so simultaneous requests grant m0 first.
